dsp_simd_sched: RTL and testbench
=================================

DSP_SIMD_SCHED -- requirements
Module: dsp_simd_sched

Interface
REQ-001 Parameter: width, default 12, lane operand/result width (1..12).
REQ-002 Parameter: latency, default 2, DSP cycles from operand issue to dsp_p valid (1..4).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
- Ports, as name, direction, width, meaning:
- clock  in  1  sole clock.
- reset  in  1  asynchronous active-low reset.
- req_valid  in  4  per-requester request valid.
- req_ready  out  4  per-requester grant; transfer occurs when req_valid[i] & req_ready[i].
- req_op  in  8  2 bits per requester: 00 AND, 01 OR, 10 XOR, 11 ADD.
- req_a  in  4*width  requester i operand A at [i*width +: width].
- req_b  in  4*width  requester i operand B at [i*width +: width].
- rsp_valid  out  4  per-requester result strobe, one cycle, no backpressure.
- rsp_y  out  4*width  requester i result at [i*width +: width].
- halt  in  1  stop issuing new requests.
- busy  out  1  any operation in flight.
- dsp_alumode  out  4  DSP ALUMODE.
- dsp_opmode  out  9  DSP OPMODE.
- dsp_ab  out  48  packed A:B lane operands (B operands).
- dsp_c  out  48  packed C lane operands (A operands).
- dsp_p  in  48  DSP result, four 12-bit SIMD lanes.

Function
REQ-004 Lane i SHALL be fixed to requester i, at bits [12*i +: 12].
REQ-005 Issue SHALL sign-extend each granted operand to 12 bits; non-granted lanes SHALL be driven 0.
REQ-006 Op encodings, as ALUMODE/OPMODE: AND 1100/000110011; OR 1100/000111011; XOR 0100/000110011; ADD 0000/000110011.
REQ-007 Arbitration is round-robin. The leader SHALL be the first valid requester at or after rr_ptr. All valid requesters whose op equals the leader's op SHALL be granted in the same cycle.
REQ-008 req_ready SHALL be combinational from req_valid, req_op, rr_ptr and state. req_ready SHALL be 0 when no request is valid or when state is not RUN.
REQ-009 On any issue, rr_ptr SHALL become (leader+1) mod 4. Otherwise rr_ptr SHALL hold.
REQ-010 An issue SHALL be possible every cycle. Control and operands SHALL be driven in the same cycle as the grant.
REQ-011 A latency-deep shift register SHALL carry the grant mask. rsp_valid SHALL equal the mask issued exactly latency cycles earlier.
REQ-012 rsp_y lane i SHALL equal dsp_p[12*i +: width], i.e. the lane result modulo 2^width. ADD carries SHALL NOT cross lanes.
REQ-013 FSM states:
- RUN: issue allowed. Goes to DRAIN when halt=1.
- DRAIN: no issue. Goes to HALTED when in-flight is empty; goes to RUN when halt=0.
- HALTED: goes to RUN when halt=0.
REQ-014 halt asserted in the same cycle as valid requests: no grant that cycle.
REQ-015 busy SHALL be 1 iff any in-flight mask bit is set.
REQ-016 When idle, dsp_alumode and dsp_opmode SHALL hold the AND encoding and all operand outputs SHALL be 0.

Reset
REQ-017 On reset assertion: state RUN, rr_ptr 0, in-flight cleared, req_ready 0, rsp_valid 0, rsp_y 0, busy 0.
REQ-018 Operations in flight at reset SHALL be discarded; no rsp_valid SHALL follow for them.
REQ-019 Reset deassertion SHALL be synchronized to clock before it affects the FSM.

Structure
REQ-020 A shared package SHALL hold:
- the op enum;
- ALUMODE/OPMODE constants per op;
- the lane count 4 and lane width 12;
- the FSM state enum.
REQ-021 Round-robin leader selection SHALL be a sub-module, rr_leader4.
REQ-022 The DSP primitive SHALL NOT be instantiated inside this block.

Verification
REQ-023 The bench SHALL model the DSP as an ideal latency-stage SIMD ALU and cover these scenarios:
- All four valid, op AND, a=0xF0F, b=0x0FF each -> req_ready=1111 in one cycle; rsp_valid=1111 at +2, each y=0x00F.
- req0 ADD and req1 XOR both valid, rr_ptr=0 -> cycle 1 grants 0001 (ALUMODE 0000), cycle 2 grants 0010 (ALUMODE 0100).
- ADD, a=0xFFF, b=0x001 on lanes 0 and 1 -> both results 0x000 with no carry into lane 1; width=8, a=0x7F, b=0x01 -> y=0x80.
- halt with 2 ops in flight -> state DRAIN, busy=1, two rsp_valid pulses, then HALTED; deassert halt -> RUN and grants resume.
- Reset asserted one cycle after an issue -> no rsp_valid; all outputs 0.
- Requester 2 continuously valid with OR, others sporadic -> every requester granted within 4 issue cycles.

Source files
------------

// File: rtl/dsp_simd_sched_pkg.sv
// Shared types and DSP control encodings for the four-lane SIMD scheduler.
package dsp_simd_sched_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 12;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b1100;
    localparam logic [3:0] ALU_OR  = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [8:0] OPM_AND = 9'b000110011;
    localparam logic [8:0] OPM_OR  = 9'b000111011;
    localparam logic [8:0] OPM_XOR = 9'b000110011;
    localparam logic [8:0] OPM_ADD = 9'b000110011;

    function automatic logic [3:0] aluModeOf(input op_e op);
        case (op)
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_ADD:  return ALU_ADD;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [8:0] opModeOf(input op_e op);
        case (op)
            OP_OR:   return OPM_OR;
            OP_XOR:  return OPM_XOR;
            OP_ADD:  return OPM_ADD;
            default: return OPM_AND;
        endcase
    endfunction

endpackage

// File: rtl/rr_leader4.sv
// Picks the first valid requester at or after the round-robin pointer.
module rr_leader4 (
    input  logic [3:0] i_valid,
    input  logic [1:0] i_ptr,
    output logic       o_found,
    output logic [1:0] o_leader
);

    logic [1:0] w_idx;

    // Scan from the farthest offset down so the nearest valid slot wins.
    always_comb begin
        o_found  = 1'b0;
        o_leader = i_ptr;
        w_idx    = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + k[1:0];
            if (i_valid[w_idx]) begin
                o_found  = 1'b1;
                o_leader = w_idx;
            end
        end
    end

endmodule

// File: rtl/dsp_simd_sched.sv
// Round-robin scheduler packing up to four same-op requests into one SIMD DSP issue.
module dsp_simd_sched
    import dsp_simd_sched_pkg::*;
#(
    parameter int width   = 12,
    parameter int latency = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           req_valid,
    output logic [3:0]           req_ready,
    input  logic [7:0]           req_op,
    input  logic [4*width-1:0]   req_a,
    input  logic [4*width-1:0]   req_b,
    output logic [3:0]           rsp_valid,
    output logic [4*width-1:0]   rsp_y,
    input  logic                 halt,
    output logic                 busy,
    output logic [3:0]           dsp_alumode,
    output logic [8:0]           dsp_opmode,
    output logic [47:0]          dsp_ab,
    output logic [47:0]          dsp_c,
    input  logic [47:0]          dsp_p
);

    logic [1:0] r_rstSync;
    logic       w_rstN;
    state_e     r_state;
    state_e     w_stateNext;
    logic [1:0] r_rrPtr;
    logic [3:0] r_pipe [latency];
    logic       w_issueOk;
    logic       w_found;
    logic [1:0] w_leader;
    op_e        w_leaderOp;
    logic       w_inflight;

    function automatic logic [LANE_W-1:0] sext(input logic [width-1:0] v);
        logic signed [LANE_W-1:0] s;
        s = $signed(v);
        return s;
    endfunction

    // Assertion is immediate; release only reaches the core after two clock edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_rstSync <= 2'b00;
        else        r_rstSync <= {r_rstSync[0], 1'b1};
    end

    assign w_rstN = r_rstSync[1];

    rr_leader4 u_leader (
        .i_valid  (req_valid),
        .i_ptr    (r_rrPtr),
        .o_found  (w_found),
        .o_leader (w_leader)
    );

    assign w_leaderOp = op_e'(req_op[{w_leader, 1'b0} +: 2]);

    always_comb begin
        w_inflight = 1'b0;
        for (int s = 0; s < latency; s++) w_inflight = w_inflight | (|r_pipe[s]);
    end

    assign busy = w_inflight;

    always_comb begin
        w_stateNext = r_state;
        w_issueOk   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_issueOk = !halt;
                if (halt) w_stateNext = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!halt)           w_stateNext = ST_RUN;
                else if (!w_inflight) w_stateNext = ST_HALTED;
            end
            ST_HALTED: begin
                if (!halt) w_stateNext = ST_RUN;
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

    // Every valid requester sharing the leader's op rides along in the same issue.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_rstN && w_issueOk && w_found && req_valid[i] && (req_op[2*i +: 2] == w_leaderOp))
                req_ready[i] = 1'b1;
        end
    end

    always_comb begin
        dsp_alumode = ALU_AND;
        dsp_opmode  = OPM_AND;
        dsp_ab      = '0;
        dsp_c       = '0;
        if (|req_ready) begin
            dsp_alumode = aluModeOf(w_leaderOp);
            dsp_opmode  = opModeOf(w_leaderOp);
        end
        for (int i = 0; i < LANES; i++) begin
            if (req_ready[i]) begin
                dsp_c[LANE_W*i +: LANE_W]  = sext(req_a[width*i +: width]);
                dsp_ab[LANE_W*i +: LANE_W] = sext(req_b[width*i +: width]);
            end
        end
    end

    always_ff @(posedge clock or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state <= ST_RUN;
            r_rrPtr <= '0;
            for (int s = 0; s < latency; s++) r_pipe[s] <= '0;
        end else begin
            r_state   <= w_stateNext;
            if (|req_ready) r_rrPtr <= w_leader + 2'd1;
            r_pipe[0] <= req_ready;
            for (int s = 1; s < latency; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign rsp_valid = r_pipe[latency-1];

    always_comb begin
        rsp_y = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rsp_valid[i]) rsp_y[width*i +: width] = dsp_p[LANE_W*i +: width];
        end
    end

endmodule

// File: tb/tb_dsp_simd_sched.sv
// Self-checking bench: ideal SIMD DSP model plus directed and randomized scheduler scenarios.
module tb_dsp_simd_sched;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        halt = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_op = '0;
    logic [47:0] req_a = '0;
    logic [47:0] req_b = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [47:0] rsp_y;
    logic        busy;
    logic [3:0]  dsp_alumode;
    logic [8:0]  dsp_opmode;
    logic [47:0] dsp_ab;
    logic [47:0] dsp_c;
    logic [47:0] dsp_p;

    logic        halt8 = 1'b0;
    logic [3:0]  valid8 = '0;
    logic [7:0]  op8 = '0;
    logic [31:0] a8 = '0;
    logic [31:0] b8 = '0;
    logic [3:0]  ready8;
    logic [3:0]  rspV8;
    logic [31:0] rspY8;
    logic        busy8;
    logic [3:0]  am8;
    logic [8:0]  om8;
    logic [47:0] ab8;
    logic [47:0] c8;
    logic [47:0] p8;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clock = ~clock;

    dsp_simd_sched #(.width(12), .latency(LAT)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
        .halt(halt), .busy(busy), .dsp_alumode(dsp_alumode), .dsp_opmode(dsp_opmode),
        .dsp_ab(dsp_ab), .dsp_c(dsp_c), .dsp_p(dsp_p)
    );

    dsp_simd_sched #(.width(8), .latency(LAT)) dut8 (
        .clock(clock), .reset(reset), .req_valid(valid8), .req_ready(ready8),
        .req_op(op8), .req_a(a8), .req_b(b8), .rsp_valid(rspV8), .rsp_y(rspY8),
        .halt(halt8), .busy(busy8), .dsp_alumode(am8), .dsp_opmode(om8),
        .dsp_ab(ab8), .dsp_c(c8), .dsp_p(p8)
    );

    // Ideal DSP: lane-isolated 12-bit ALU, result appears LAT cycles after issue.
    function automatic logic [47:0] dspCalc(input logic [3:0] am, input logic [8:0] om,
                                            input logic [47:0] c, input logic [47:0] ab);
        logic [47:0] p;
        logic [11:0] z, x;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            z = c[12*i +: 12];
            x = ab[12*i +: 12];
            case (am)
                4'b0000: p[12*i +: 12] = z + x;
                4'b0100: p[12*i +: 12] = z ^ x;
                default: p[12*i +: 12] = om[3] ? (z | x) : (z & x);
            endcase
        end
        return p;
    endfunction

    logic [47:0] pipe12 [LAT];
    logic [47:0] pipe8  [LAT];

    initial begin
        for (int s = 0; s < LAT; s++) begin
            pipe12[s] = '0;
            pipe8[s]  = '0;
        end
    end

    always @(posedge clock) begin
        for (int s = LAT - 1; s > 0; s--) begin
            pipe12[s] <= pipe12[s-1];
            pipe8[s]  <= pipe8[s-1];
        end
        pipe12[0] <= dspCalc(dsp_alumode, dsp_opmode, dsp_c, dsp_ab);
        pipe8[0]  <= dspCalc(am8, om8, c8, ab8);
    end

    assign dsp_p = pipe12[LAT-1];
    assign p8    = pipe8[LAT-1];

    function automatic logic [11:0] refOp(input logic [1:0] op, input logic [11:0] a, input logic [11:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [3:0] refAlu(input logic [1:0] op);
        case (op)
            2'b10:   return 4'b0100;
            2'b11:   return 4'b0000;
            default: return 4'b1100;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] v, input logic [7:0] op,
                                 input logic [47:0] a, input logic [47:0] b, input logic h);
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        halt      = h;
    endtask

    task automatic doReset();
        applyStimulus(4'h0, 8'h00, '0, '0, 1'b0);
        valid8 = '0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        applyStimulus(4'hF, 8'hFF, {4{12'hABC}}, {4{12'h123}}, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #1;
        checkCount++; if (req_ready !== 4'h0) begin errorCount++; $display("[TB] FAIL reset_ready got %h expected 0", req_ready); end
        checkCount++; if (rsp_valid !== 4'h0) begin errorCount++; $display("[TB] FAIL reset_rsp_valid got %h expected 0", rsp_valid); end
        checkCount++; if (rsp_y !== 48'h0) begin errorCount++; $display("[TB] FAIL reset_rsp_y got %h expected 0", rsp_y); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checkCount++; if ({dsp_alumode, dsp_opmode} !== {4'b1100, 9'b000110011}) begin errorCount++; $display("[TB] FAIL reset_ctrl got %h/%h expected c/033", dsp_alumode, dsp_opmode); end
        checkCount++; if ({dsp_ab, dsp_c} !== 96'h0) begin errorCount++; $display("[TB] FAIL reset_operands got %h %h expected 0", dsp_ab, dsp_c); end
        doReset();
    endtask

    task automatic test_all_and();
        doReset();
        applyStimulus(4'hF, 8'h00, {4{12'hF0F}}, {4{12'h0FF}}, 1'b0);
        #1;
        checkCount++; if (req_ready !== 4'hF) begin errorCount++; $display("[TB] FAIL and_ready got %h expected f", req_ready); end
        checkCount++; if (dsp_c !== {4{12'hF0F}}) begin errorCount++; $display("[TB] FAIL and_dsp_c got %h expected %h", dsp_c, {4{12'hF0F}}); end
        checkCount++; if (dsp_ab !== {4{12'h0FF}}) begin errorCount++; $display("[TB] FAIL and_dsp_ab got %h expected %h", dsp_ab, {4{12'h0FF}}); end
        checkCount++; if ({dsp_alumode, dsp_opmode} !== {4'b1100, 9'b000110011}) begin errorCount++; $display("[TB] FAIL and_ctrl got %h/%h expected c/033", dsp_alumode, dsp_opmode); end
        @(negedge clock);
        applyStimulus(4'h0, 8'h00, '0, '0, 1'b0);
        #1;
        checkCount++; if (rsp_valid !== 4'h0) begin errorCount++; $display("[TB] FAIL and_early_rsp got %h expected 0", rsp_valid); end
        checkCount++; if (busy !== 1'b1) begin errorCount++; $display("[TB] FAIL and_busy got %b expected 1", busy); end
        @(negedge clock);
        #1;
        checkCount++; if (rsp_valid !== 4'hF) begin errorCount++; $display("[TB] FAIL and_rsp_valid got %h expected f", rsp_valid); end
        checkCount++; if (rsp_y !== {4{12'h00F}}) begin errorCount++; $display("[TB] FAIL and_rsp_y got %h expected %h", rsp_y, {4{12'h00F}}); end
        @(negedge clock);
        #1;
        checkCount++; if ({rsp_valid, busy} !== 5'b0) begin errorCount++; $display("[TB] FAIL and_idle got %h/%b expected 0/0", rsp_valid, busy); end
    endtask

    task automatic test_arb_order();
        doReset();
        applyStimulus(4'b0011, 8'b0000_1011, {24'h0, 12'h0F0, 12'h123}, {24'h0, 12'h0FF, 12'h456}, 1'b0);
        #1;
        checkCount++; if (req_ready !== 4'b0001) begin errorCount++; $display("[TB] FAIL arb_first_grant got %b expected 0001", req_ready); end
        checkCount++; if (dsp_alumode !== 4'b0000) begin errorCount++; $display("[TB] FAIL arb_first_alu got %b expected 0000", dsp_alumode); end
        @(negedge clock);
        applyStimulus(4'b0010, 8'b0000_1011, {24'h0, 12'h0F0, 12'h123}, {24'h0, 12'h0FF, 12'h456}, 1'b0);
        #1;
        checkCount++; if (req_ready !== 4'b0010) begin errorCount++; $display("[TB] FAIL arb_second_grant got %b expected 0010", req_ready); end
        checkCount++; if (dsp_alumode !== 4'b0100) begin errorCount++; $display("[TB] FAIL arb_second_alu got %b expected 0100", dsp_alumode); end
        @(negedge clock);
        applyStimulus(4'h0, 8'h00, '0, '0, 1'b0);
        #1;
        checkCount++; if ({rsp_valid, rsp_y[11:0]} !== {4'b0001, 12'h579}) begin errorCount++; $display("[TB] FAIL arb_add_result got %b/%h expected 0001/579", rsp_valid, rsp_y[11:0]); end
        @(negedge clock);
        #1;
        checkCount++; if ({rsp_valid, rsp_y[23:12]} !== {4'b0010, 12'h00F}) begin errorCount++; $display("[TB] FAIL arb_xor_result got %b/%h expected 0010/00f", rsp_valid, rsp_y[23:12]); end
        @(negedge clock);
    endtask

    task automatic test_add_lanes();
        doReset();
        applyStimulus(4'b0011, 8'b0000_1111, {24'h0, 12'hFFF, 12'hFFF}, {24'h0, 12'h001, 12'h001}, 1'b0);
        valid8 = 4'b0001;
        op8    = 8'b0000_0011;
        a8     = 32'h0000_007F;
        b8     = 32'h0000_0001;
        #1;
        checkCount++; if (req_ready !== 4'b0011) begin errorCount++; $display("[TB] FAIL add_ready got %b expected 0011", req_ready); end
        checkCount++; if (ready8 !== 4'b0001) begin errorCount++; $display("[TB] FAIL add8_ready got %b expected 0001", ready8); end
        @(negedge clock);
        applyStimulus(4'h0, 8'h00, '0, '0, 1'b0);
        valid8 = '0;
        @(negedge clock);
        #1;
        checkCount++; if ({rsp_valid, rsp_y[23:0]} !== {4'b0011, 24'h0}) begin errorCount++; $display("[TB] FAIL add_no_carry got %b/%h expected 0011/000000", rsp_valid, rsp_y[23:0]); end
        checkCount++; if ({rspV8, rspY8[7:0]} !== {4'b0001, 8'h80}) begin errorCount++; $display("[TB] FAIL add8_result got %b/%h expected 0001/80", rspV8, rspY8[7:0]); end
        @(negedge clock);
    endtask

    task automatic test_halt();
        int pulses;
        bit drained;
        bit resumed;
        doReset();
        applyStimulus(4'b0001, 8'b0000_0000, {36'h0, 12'h0F0}, {36'h0, 12'h0CC}, 1'b0);
        #1;
        checkCount++; if (req_ready !== 4'b0001) begin errorCount++; $display("[TB] FAIL halt_issue0 got %b expected 0001", req_ready); end
        @(negedge clock);
        applyStimulus(4'b0010, 8'b0000_0100, {24'h0, 12'h0F0, 12'h0}, {24'h0, 12'h00F, 12'h0}, 1'b0);
        #1;
        checkCount++; if (req_ready !== 4'b0010) begin errorCount++; $display("[TB] FAIL halt_issue1 got %b expected 0010", req_ready); end
        @(negedge clock);
        applyStimulus(4'b0100, 8'b0010_0000, {12'h0, 12'h555, 24'h0}, {12'h0, 12'h0AA, 24'h0}, 1'b1);
        pulses  = 0;
        drained = 1'b0;
        for (int k = 0; k < 10 && !drained; k++) begin
            #1;
            if (k == 0) begin
                checkCount++; if (busy !== 1'b1) begin errorCount++; $display("[TB] FAIL halt_busy got %b expected 1", busy); end
            end
            if (rsp_valid != 4'h0) pulses++;
            checkCount++; if (req_ready !== 4'h0) begin errorCount++; $display("[TB] FAIL halt_no_grant got %b expected 0", req_ready); end
            if (busy === 1'b0) drained = 1'b1;
            else @(negedge clock);
        end
        checkCount++; if (!drained) begin errorCount++; $display("[TB] FAIL halt_drain_timeout got busy=%b expected 0", busy); end
        checkCount++; if (pulses != 2) begin errorCount++; $display("[TB] FAIL halt_pulses got %0d expected 2", pulses); end
        repeat (2) @(negedge clock);
        #1;
        checkCount++; if ({req_ready, busy} !== 5'b0) begin errorCount++; $display("[TB] FAIL halted_idle got %b/%b expected 0/0", req_ready, busy); end
        @(negedge clock);
        halt = 1'b0;
        resumed = 1'b0;
        for (int k = 0; k < 5 && !resumed; k++) begin
            #1;
            if (req_ready != 4'h0) resumed = 1'b1;
            else @(negedge clock);
        end
        checkCount++; if (req_ready !== 4'b0100) begin errorCount++; $display("[TB] FAIL halt_resume got %b expected 0100", req_ready); end
        @(negedge clock);
        applyStimulus(4'h0, 8'h00, '0, '0, 1'b0);
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_inflight();
        bit sawRsp;
        doReset();
        applyStimulus(4'hF, 8'h00, {4{12'hFFF}}, {4{12'hFFF}}, 1'b0);
        #1;
        checkCount++; if (req_ready !== 4'hF) begin errorCount++; $display("[TB] FAIL rstfl_issue got %h expected f", req_ready); end
        @(negedge clock);
        applyStimulus(4'h0, 8'h00, '0, '0, 1'b0);
        reset = 1'b0;
        #1;
        checkCount++; if ({rsp_valid, busy, req_ready} !== 9'b0) begin errorCount++; $display("[TB] FAIL rstfl_ctrl got %b/%b/%b expected 0", rsp_valid, busy, req_ready); end
        checkCount++; if ({rsp_y, dsp_ab, dsp_c} !== 144'h0) begin errorCount++; $display("[TB] FAIL rstfl_data got %h expected 0", rsp_y); end
        @(negedge clock);
        reset = 1'b1;
        sawRsp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (rsp_valid != 4'h0) sawRsp = 1'b1;
            @(negedge clock);
        end
        checkCount++; if (sawRsp) begin errorCount++; $display("[TB] FAIL rstfl_ghost_rsp got pulse expected none"); end
    endtask

    task automatic test_round_robin_fair();
        logic [3:0]  vld;
        logic [1:0]  opq [4];
        logic [11:0] aq [4];
        logic [11:0] bq [4];
        int          waitCnt [4];
        logic [1:0]  ptr;
        logic [3:0]  expMask [2];
        logic [11:0] expY [2][4];
        logic [3:0]  grant;
        int          leader;
        logic [7:0]  ov;
        logic [47:0] av, bv;
        doReset();
        vld = '0;
        ptr = '0;
        for (int s = 0; s < 2; s++) begin
            expMask[s] = '0;
            for (int i = 0; i < 4; i++) expY[s][i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            waitCnt[i] = 0;
            opq[i] = '0;
            aq[i] = '0;
            bq[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!vld[i] && (i == 2 || $urandom_range(0, 2) == 0)) begin
                    vld[i] = 1'b1;
                    opq[i] = (i == 2) ? 2'b01 : 2'($urandom_range(0, 3));
                    aq[i]  = 12'($urandom);
                    bq[i]  = 12'($urandom);
                end
                ov[2*i +: 2]  = opq[i];
                av[12*i +: 12] = aq[i];
                bv[12*i +: 12] = bq[i];
            end
            applyStimulus(vld, ov, av, bv, 1'b0);
            #1;
            leader = -1;
            for (int k = 0; k < 4; k++) begin
                if (leader < 0 && vld[(int'(ptr) + k) % 4]) leader = (int'(ptr) + k) % 4;
            end
            grant = '0;
            if (leader >= 0) begin
                for (int i = 0; i < 4; i++) if (vld[i] && opq[i] == opq[leader]) grant[i] = 1'b1;
            end
            checkCount++; if (req_ready !== grant) begin errorCount++; $display("[TB] FAIL rr_grant cyc %0d got %b expected %b", cyc, req_ready, grant); end
            if (grant != 4'h0) begin
                checkCount++; if (dsp_alumode !== refAlu(opq[leader])) begin errorCount++; $display("[TB] FAIL rr_alumode cyc %0d got %b expected %b", cyc, dsp_alumode, refAlu(opq[leader])); end
            end
            checkCount++; if (rsp_valid !== expMask[1]) begin errorCount++; $display("[TB] FAIL rr_rsp_valid cyc %0d got %b expected %b", cyc, rsp_valid, expMask[1]); end
            for (int i = 0; i < 4; i++) begin
                if (expMask[1][i]) begin
                    checkCount++; if (rsp_y[12*i +: 12] !== expY[1][i]) begin errorCount++; $display("[TB] FAIL rr_rsp_y cyc %0d lane %0d got %h expected %h", cyc, i, rsp_y[12*i +: 12], expY[1][i]); end
                end
            end
            expMask[1] = expMask[0];
            expMask[0] = grant;
            for (int i = 0; i < 4; i++) begin
                expY[1][i] = expY[0][i];
                expY[0][i] = grant[i] ? refOp(opq[i], aq[i], bq[i]) : 12'h0;
            end
            if (grant != 4'h0) begin
                ptr = 2'((leader + 1) % 4);
                for (int i = 0; i < 4; i++) begin
                    if (grant[i]) begin
                        vld[i] = 1'b0;
                        waitCnt[i] = 0;
                    end else if (vld[i]) begin
                        waitCnt[i]++;
                        checkCount++; if (waitCnt[i] > 3) begin errorCount++; $display("[TB] FAIL rr_starve cyc %0d req %0d waited %0d issues expected at most 3", cyc, i, waitCnt[i]); end
                    end
                end
            end
            @(negedge clock);
        end
        applyStimulus(4'h0, 8'h00, '0, '0, 1'b0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_all_and();
        test_arb_order();
        test_add_lanes();
        test_halt();
        test_reset_inflight();
        test_round_robin_fair();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
